// File: rtl/iir_feeder_if.sv
// rtl/iir_feeder_if.sv - upstream sample handshake and cascade-side sample bus for iir_feeder
interface iir_feeder_if #(
    parameter int DWIDTH = 24
) ();
    logic              in_vld;
    logic              in_rdy;
    logic [DWIDTH-1:0] in_data;
    logic              din_vld;
    logic [DWIDTH-1:0] din;

    modport slave (
        input  in_vld,
        input  in_data,
        output in_rdy,
        output din_vld,
        output din
    );

    modport master (
        output in_vld,
        output in_data,
        input  in_rdy,
        input  din_vld,
        input  din
    );
endinterface

// File: rtl/iir_feeder.sv
// rtl/iir_feeder.sv - FIFO plus pacing FSM feeding the IIR cascade one sample per SPACING cycles
// Optional macro IIR_FEEDER_DROP_EN: discard and count samples on overflow instead of backpressuring.
module iir_feeder #(
    parameter int DWIDTH  = 24,
    parameter int DEPTH   = 8,
    parameter int SPACING = 12,
    parameter int LWIDTH  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              block_en,
    iir_feeder_if.slave       bus,
    output logic [LWIDTH-1:0] fifo_level,
    output logic [15:0]       drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = (SPACING > 2) ? $clog2(SPACING) : 1;
    localparam bit BYPASS = (SPACING <= 1);
    localparam logic [GW-1:0] GAP_LOAD = (SPACING >= 2) ? GW'(SPACING - 2) : '0;

    typedef enum logic {
        READY   = 1'b0,
        HOLDOFF = 1'b1
    } state_t;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [LWIDTH-1:0] level_q;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;

    state_t            state_q;
    state_t            state_d;
    logic [GW-1:0]     gap_q;
    logic [GW-1:0]     gap_d;
    logic              vld_q;
    logic              vld_d;
    logic [DWIDTH-1:0] din_q;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

`ifdef IIR_FEEDER_DROP_EN
    logic        drop;
    logic [15:0] drop_q;

    // A simultaneous pop frees the head slot, so a write while full is still a real push.
    assign bus.in_rdy = rstn && block_en;
    assign push       = bus.in_vld && block_en && (!full || pop);
    assign drop       = bus.in_vld && block_en && full && !pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_q <= '0;
        end else if (!block_en) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign bus.in_rdy = rstn && block_en && !full;
    assign push       = bus.in_vld && bus.in_rdy;
    assign drop_cnt   = 16'h0000;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (!block_en) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= READY;
            gap_q   <= '0;
            vld_q   <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            vld_q   <= vld_d;
            if (!block_en) begin
                din_q <= '0;
            end else if (pop) begin
                din_q <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // gap_cnt counts down to zero, then one extra cycle in HOLDOFF makes the spacing exactly SPACING.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pop     = 1'b0;
        vld_d   = 1'b0;
        case (state_q)
            READY: begin
                if (!empty) begin
                    pop   = 1'b1;
                    vld_d = 1'b1;
                    if (!BYPASS) begin
                        state_d = HOLDOFF;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            HOLDOFF: begin
                if (gap_q == '0) begin
                    state_d = READY;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = READY;
        endcase
        if (!block_en) begin
            state_d = READY;
            gap_d   = '0;
            pop     = 1'b0;
            vld_d   = 1'b0;
        end
    end

    assign bus.din_vld = vld_q;
    assign bus.din     = din_q;
    assign fifo_level  = level_q;
endmodule

// File: tb/tb_iir_feeder.sv
// tb/tb_iir_feeder.sv - self-checking bench for iir_feeder (table vectors plus scoreboard queue)
module tb_iir_feeder;
    localparam int DW      = 24;
    localparam int DEPTH   = 8;
    localparam int SPACING = 12;
    localparam int LW      = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          block_en;
    logic [LW-1:0] fifo_level;
    logic [15:0]   drop_cnt;

    iir_feeder_if #(.DWIDTH(DW)) bus ();

    iir_feeder #(
        .DWIDTH (DW),
        .DEPTH  (DEPTH),
        .SPACING(SPACING),
        .LWIDTH (LW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .block_en  (block_en),
        .bus       (bus),
        .fifo_level(fifo_level),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [DW-1:0] e;
    } vec_t;

    vec_t          vt [5];
    logic [DW-1:0] exp_q [$];
    int            pulse_q [$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            last_cyc = 0;
    bit            have_last = 0;
    int            peak = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && bus.din_vld) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse actual din=%0h required=no pulse", bus.din);
            end else begin
                chk("din_order", 32'(bus.din), 32'(exp_q.pop_front()));
            end
            if (have_last) chk("spacing_min", 32'((cyc - last_cyc) >= SPACING), 32'd1);
            last_cyc  = cyc;
            have_last = 1'b1;
            pulse_q.push_back(cyc);
        end
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end

    task automatic flush_sb();
        exp_q.delete();
        pulse_q.delete();
        have_last = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, output bit acc, output int lvl);
        @(negedge clk);
        bus.in_vld  = 1'b1;
        bus.in_data = d;
        #1;
        acc = bus.in_rdy;
        lvl = int'(fifo_level);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_vld = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (SPACING) @(negedge clk);
    endtask

    task automatic single(input logic [DW-1:0] d, input logic [DW-1:0] e);
        bit acc;
        int lvl;
        send(d, acc, lvl);
        chk("single_acc", 32'(acc), 32'd1);
        exp_q.push_back(e);
        @(negedge clk);
        bus.in_vld = 1'b0;
        chk("lat1_vld", 32'(bus.din_vld), 32'd0);
        chk("lat1_level", 32'(fifo_level), 32'd1);
        @(negedge clk);
        chk("lat2_vld", 32'(bus.din_vld), 32'd1);
        chk("lat2_din", 32'(bus.din), 32'(e));
        chk("lat2_level", 32'(fifo_level), 32'd0);
        repeat (SPACING) @(negedge clk);
        chk("hold_vld", 32'(bus.din_vld), 32'd0);
        chk("hold_din", 32'(bus.din), 32'(e));
    endtask

    initial begin
        bit acc;
        int lvl;
        int i;
        int guard;
        bit stall;

        vt[0] = '{d: 24'h123456, e: 24'h123456};
        vt[1] = '{d: 24'h800000, e: 24'h800000};
        vt[2] = '{d: 24'h7FFFFF, e: 24'h7FFFFF};
        vt[3] = '{d: 24'hFFFFFF, e: 24'hFFFFFF};
        vt[4] = '{d: 24'h000001, e: 24'h000001};

        rstn        = 1'b0;
        block_en    = 1'b1;
        bus.in_vld  = 1'b0;
        bus.in_data = '0;
        #12;
        chk("rst_rdy", 32'(bus.in_rdy), 32'd0);
        chk("rst_vld", 32'(bus.din_vld), 32'd0);
        chk("rst_din", 32'(bus.din), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rdy_after_rst", 32'(bus.in_rdy), 32'd1);
        repeat (2) @(negedge clk);

        for (int k = 0; k < 5; k++) single(vt[k].d, vt[k].e);

        flush_sb();
        peak = 0;
        for (int k = 1; k <= 8; k++) begin
            send(DW'(k), acc, lvl);
            chk("burst_acc", 32'(acc), 32'd1);
            exp_q.push_back(DW'(k));
        end
        idle();
        drain(300);
        chk("burst_pulses", 32'(pulse_q.size()), 32'd8);
        for (int k = 1; k < pulse_q.size(); k++)
            chk("burst_gap", 32'(pulse_q[k] - pulse_q[k-1]), 32'(SPACING));
        chk("burst_peak", 32'(peak == 7 || peak == 8), 32'd1);

        flush_sb();
`ifdef IIR_FEEDER_DROP_EN
        for (int k = 1; k <= 12; k++) begin
            send(DW'(k), acc, lvl);
            chk("drop_rdy", 32'(acc), 32'd1);
            if (k <= 9) exp_q.push_back(DW'(k));
        end
        idle();
        chk("drop_cnt", 32'(drop_cnt), 32'd3);
        drain(300);
        chk("drop_pulses", 32'(pulse_q.size()), 32'd9);
`else
        i     = 1;
        guard = 0;
        stall = 1'b0;
        while (i <= 12 && guard < 100) begin
            send(DW'(i), acc, lvl);
            guard++;
            if (acc) begin
                exp_q.push_back(DW'(i));
                i++;
            end else begin
                if (!stall) chk("stall_level", 32'(lvl), 32'd8);
                stall = 1'b1;
            end
        end
        idle();
        chk("stall_seen", 32'(stall), 32'd1);
        chk("all_sent", 32'(i), 32'd13);
        drain(400);
        chk("bp_pulses", 32'(pulse_q.size()), 32'd12);
        chk("bp_drop", 32'(drop_cnt), 32'd0);
`endif

        flush_sb();
        for (int k = 1; k <= 6; k++) begin
            send(DW'(24'h100 + k), acc, lvl);
            exp_q.push_back(DW'(24'h100 + k));
        end
        @(negedge clk);
        bus.in_vld = 1'b0;
        block_en   = 1'b0;
        chk("blk_level_before", 32'(fifo_level), 32'd5);
        #1;
        chk("blk_rdy", 32'(bus.in_rdy), 32'd0);
        @(negedge clk);
        flush_sb();
        chk("blk_level", 32'(fifo_level), 32'd0);
        chk("blk_din", 32'(bus.din), 32'd0);
        chk("blk_vld", 32'(bus.din_vld), 32'd0);
        chk("blk_drop", 32'(drop_cnt), 32'd0);
        block_en = 1'b1;
        single(24'hABCDEF, 24'hABCDEF);

        flush_sb();
        for (int k = 1; k <= 3; k++) begin
            send(DW'(24'h200 + k), acc, lvl);
            exp_q.push_back(DW'(24'h200 + k));
        end
        idle();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_vld", 32'(bus.din_vld), 32'd0);
        chk("arst_din", 32'(bus.din), 32'd0);
        chk("arst_level", 32'(fifo_level), 32'd0);
        chk("arst_rdy", 32'(bus.in_rdy), 32'd0);
        chk("arst_drop", 32'(drop_cnt), 32'd0);
        flush_sb();
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("arst_no_pulse", 32'(pulse_q.size()), 32'd0);
        single(24'h5A5A5A, 24'h5A5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
